instruction_fetch_unit: RTL and testbench

//   Reader side of the 16x8 combinational instruction ROM. Owns the program counter,

---
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: ROM read port, IR handshake to the decoder, and control/status.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned INSTR_WIDTH = 8
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic [INSTR_WIDTH-1:0] ir_out;
    logic [ADDR_WIDTH-1:0]  ir_pc;
    logic                   ir_valid;
    logic                   ir_ready;
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic [ADDR_WIDTH-1:0]  pc_out;
    logic                   halted;

    // Fetch unit side
    modport master (
        input  start, imem_instr, ir_ready, branch_taken, branch_target,
        output imem_addr, ir_out, ir_pc, ir_valid, pc_out, halted
    );

    // Environment side (ROM, decoder, control)
    modport slave (
        output start, imem_instr, ir_ready, branch_taken, branch_target,
        input  imem_addr, ir_out, ir_pc, ir_valid, pc_out, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational ROM and registers each word
// into the IR, handed to the decoder over valid/ready. Handles stalls, branch flushes,
// PC wrap-around and HALT detection.
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 4,
    parameter int unsigned           INSTR_WIDTH = 8,
    parameter logic [3:0]            HALT_OPCODE = 4'b0111,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [ADDR_WIDTH-1:0]  ir_pc_q, ir_pc_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   halted_q, halted_d;

    logic       load;
    logic [3:0] opcode;

    assign opcode = bus.imem_instr[INSTR_WIDTH-1 -: 4];

    // Next-state logic: branch beats load, load beats stall; HALT freezes the PC.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        load       = ~ir_valid_q | bus.ir_ready;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (bus.branch_taken) begin
                    // Flush: the wrong-path word in the IR is dropped, no fetch this cycle.
                    pc_d       = bus.branch_target;
                    ir_valid_d = 1'b0;
                end else if (load) begin
                    ir_d       = bus.imem_instr;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (opcode == HALT_OPCODE) begin
                        state_d  = StHalted;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StHalted: begin
                if (bus.start) begin
                    pc_d       = RESET_PC;
                    ir_valid_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = StFetch;
                end else if (bus.ir_ready) begin
                    // HALT word is consumed once, then nothing more is presented.
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc_out    = pc_q;
    assign bus.ir_out    = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural 16x8 ROM.
module tb_instruction_fetch_unit;

    logic clk;
    logic reset;
    logic [7:0] rom [16];

    int unsigned n_checks;
    int unsigned n_errors;

    instruction_fetch_unit_if #(.ADDR_WIDTH(4), .INSTR_WIDTH(8)) bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_instr = rom[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_program();
        logic [7:0] prog [8];
        prog = '{8'h05, 8'h03, 8'h21, 8'h02, 8'h32, 8'h41, 8'h51, 8'h70};
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? prog[i] : 8'h00;
    endtask

    // Pulse start, then confirm restart and the first word two edges later.
    task automatic start_and_first();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_pc", 32'(bus.pc_out), 32'h0);
        check("start_halted", 32'(bus.halted), 32'h0);
        check("start_valid", 32'(bus.ir_valid), 32'h0);
        step();
        check("first_ir", 32'(bus.ir_out), 32'h05);
        check("first_valid", 32'(bus.ir_valid), 32'h1);
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h05, 8'h03, 8'h21, 8'h02, 8'h32, 8'h41, 8'h51, 8'h70};
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ir_ready = 1'b1;
        bus.branch_taken = 1'b0;
        bus.branch_target = 4'd0;
        load_program();

        step();
        step();
        check("rst_valid", 32'(bus.ir_valid), 32'h0);
        check("rst_pc", 32'(bus.pc_out), 32'h0);
        check("rst_halted", 32'(bus.halted), 32'h0);
        check("rst_ir", 32'(bus.ir_out), 32'h0);
        check("rst_irpc", 32'(bus.ir_pc), 32'h0);
        reset = 1'b0;
        step();
        check("idle_no_fetch", 32'(bus.ir_valid), 32'h0);

        // Full program, one word per cycle, ending at HALT.
        start_and_first();
        check("seq_irpc0", 32'(bus.ir_pc), 32'h0);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("seq_ir%0d", i), 32'(bus.ir_out), 32'(exp_seq[i]));
            check($sformatf("seq_irpc%0d", i), 32'(bus.ir_pc), 32'(i));
        end
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_pc", 32'(bus.pc_out), 32'h7);
        step();
        check("halt_consumed", 32'(bus.ir_valid), 32'h0);
        check("halt_pc_hold", 32'(bus.pc_out), 32'h7);
        check("halt_flag_hold", 32'(bus.halted), 32'h1);
        bus.branch_taken = 1'b1;
        bus.branch_target = 4'd3;
        step();
        bus.branch_taken = 1'b0;
        check("halt_ignores_branch", 32'(bus.pc_out), 32'h7);
        check("halt_no_load", 32'(bus.ir_valid), 32'h0);

        // Restart, then branch to 5 while 03 is in the IR.
        start_and_first();
        step();
        check("pre_branch_ir", 32'(bus.ir_out), 32'h03);
        bus.branch_taken = 1'b1;
        bus.branch_target = 4'd5;
        step();
        bus.branch_taken = 1'b0;
        check("branch_flush", 32'(bus.ir_valid), 32'h0);
        check("branch_pc", 32'(bus.pc_out), 32'h5);
        step();
        check("branch_ir", 32'(bus.ir_out), 32'h41);
        check("branch_irpc", 32'(bus.ir_pc), 32'h5);
        check("branch_valid", 32'(bus.ir_valid), 32'h1);
        step();
        step();
        check("branch_halt", 32'(bus.halted), 32'h1);
        step();

        // Restart and stall three cycles on 21.
        start_and_first();
        step();
        step();
        check("stall_ir_pre", 32'(bus.ir_out), 32'h21);
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ir", 32'(bus.ir_out), 32'h21);
            check("stall_irpc", 32'(bus.ir_pc), 32'h2);
            check("stall_pc", 32'(bus.pc_out), 32'h3);
            check("stall_valid", 32'(bus.ir_valid), 32'h1);
        end
        bus.ir_ready = 1'b1;
        step();
        check("unstall_ir", 32'(bus.ir_out), 32'h02);
        check("unstall_pc", 32'(bus.pc_out), 32'h4);

        // Asynchronous reset mid-stream.
        reset = 1'b1;
        #1;
        check("async_valid", 32'(bus.ir_valid), 32'h0);
        check("async_pc", 32'(bus.pc_out), 32'h0);
        check("async_halted", 32'(bus.halted), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle_valid", 32'(bus.ir_valid), 32'h0);
            check("post_rst_idle_pc", 32'(bus.pc_out), 32'h0);
        end

        // No HALT in ROM: PC wraps 15 -> 0 and keeps fetching.
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("wrap_pc0", 32'(bus.pc_out), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            step();
            check($sformatf("wrap_pc%0d", k), 32'(bus.pc_out), 32'(k % 16));
            check($sformatf("wrap_irpc%0d", k), 32'(bus.ir_pc), 32'((k - 1) % 16));
            check("wrap_valid", 32'(bus.ir_valid), 32'h1);
        end
        check("wrap_no_halt", 32'(bus.halted), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
